// File: rtl/control_pkg.sv
// Shared types and encodings for the stack-machine control unit.
// Opcode values and the output field encodings live here so decode and FSM agree.
package control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [3:0] OP_ALU   = 4'd0;
  localparam logic [3:0] OP_PUSHI = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_JUMP  = 4'd4;
  localparam logic [3:0] OP_BZ    = 4'd5;
  localparam logic [3:0] OP_CALL  = 4'd6;
  localparam logic [3:0] OP_RET   = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd8;

  localparam logic [2:0] SOP_NOP       = 3'd0;
  localparam logic [2:0] SOP_PUSH      = 3'd1;
  localparam logic [2:0] SOP_POP2PUSH1 = 3'd2;
  localparam logic [2:0] SOP_POP       = 3'd3;
  localparam logic [2:0] SOP_POP1PUSH1 = 3'd4;

  localparam logic [1:0] RSOP_NOP  = 2'd0;
  localparam logic [1:0] RSOP_PUSH = 2'd1;
  localparam logic [1:0] RSOP_POP  = 2'd2;

  localparam logic [2:0] SC_NONE = 3'd0;
  localparam logic [2:0] SC_IMM  = 3'd1;
  localparam logic [2:0] SC_MEM  = 3'd2;
  localparam logic [2:0] SC_ALU  = 3'd3;
  localparam logic [2:0] SC_RTOP = 3'd4;

  localparam logic [2:0] PC_HOLD = 3'd0;
  localparam logic [2:0] PC_JMP  = 3'd1;
  localparam logic [2:0] PC_BZ   = 3'd2;
  localparam logic [2:0] PC_RTOP = 3'd3;
  localparam logic [2:0] PC_INC  = 3'd4;

  typedef struct packed {
    logic [2:0] stack_op;
    logic [1:0] rstack_op;
    logic [2:0] stack_ctrl;
    logic [2:0] pc_ctrl;
  } ctrl_t;

endpackage

// File: rtl/control_mc_if.sv
// Instruction/data memory handshake between the control unit and memory.
interface control_mc_if #(
  parameter int INST_W = 16
) ();
  logic [INST_W-1:0] inst;
  logic              mem_ack;
  logic              mem_req;
  logic              MemWrite;

  modport master (output mem_req, output MemWrite, input inst, input mem_ack);
  modport slave  (input mem_req, input MemWrite, output inst, output mem_ack);
endinterface

// File: rtl/control_decode.sv
// Combinational instruction decode: IR -> control word plus class flags.
module control_decode
  import control_pkg::*;
#(
  parameter int INST_W    = 16,
  parameter int FUNCT_W   = 4,
  parameter int NUM_FUNCT = 12
) (
  input  logic [INST_W-1:0]  ir,
  output ctrl_t              ctrl,
  output logic [FUNCT_W-1:0] alu_op,
  output logic               is_mem,
  output logic               is_store,
  output logic               is_halt,
  output logic               is_illegal
);

  localparam logic [FUNCT_W:0] NUM_F = (FUNCT_W+1)'(NUM_FUNCT);

  logic [3:0]         opcode;
  logic [FUNCT_W-1:0] funct;
  logic               unused_imm;

  assign opcode     = ir[INST_W-1:INST_W-4];
  assign funct      = ir[FUNCT_W-1:0];
  // Immediate bits are consumed by the datapath, not by control.
  assign unused_imm = ^ir[INST_W-5:FUNCT_W];

  always_comb begin
    ctrl       = '0;
    alu_op     = '0;
    is_mem     = 1'b0;
    is_store   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ALU: begin
        if ({1'b0, funct} >= NUM_F) begin
          is_illegal = 1'b1;
        end else begin
          ctrl   = '{SOP_POP2PUSH1, RSOP_NOP, SC_ALU, PC_INC};
          alu_op = funct;
        end
      end
      OP_PUSHI: ctrl = '{SOP_PUSH, RSOP_NOP, SC_IMM, PC_INC};
      OP_LOAD: begin
        ctrl   = '{SOP_POP1PUSH1, RSOP_NOP, SC_MEM, PC_INC};
        is_mem = 1'b1;
      end
      OP_STORE: begin
        ctrl     = '{SOP_POP, RSOP_NOP, SC_NONE, PC_INC};
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OP_JUMP: ctrl = '{SOP_NOP, RSOP_NOP, SC_NONE, PC_JMP};
      OP_BZ:   ctrl = '{SOP_POP, RSOP_NOP, SC_NONE, PC_BZ};
      OP_CALL: ctrl = '{SOP_NOP, RSOP_PUSH, SC_NONE, PC_JMP};
      OP_RET:  ctrl = '{SOP_NOP, RSOP_POP, SC_NONE, PC_RTOP};
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_mc.sv
// Multi-cycle control FSM for the stack machine: fetch, decode, execute/memory,
// with sticky HALT/TRAP and a retired-instruction counter.
module control_mc
  import control_pkg::*;
#(
  parameter int INST_W    = 16,
  parameter int FUNCT_W   = 4,
  parameter int NUM_FUNCT = 12,
  parameter int CNT_W     = 16
) (
  input  logic               CLK,
  input  logic               reset,
  control_mc_if.master       bus,
  output logic               IRWrite,
  output logic [2:0]         stackOP,
  output logic [1:0]         rStackOP,
  output logic [2:0]         stackControl,
  output logic [2:0]         PCControl,
  output logic [FUNCT_W-1:0] ALUOP,
  output logic               PCWrite,
  output logic               halted,
  output logic               trap,
  output logic [CNT_W-1:0]   retired
);

  state_e             state_q, state_d;
  logic [INST_W-1:0]  ir_q, ir_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  ctrl_t              dec_ctrl;
  logic [FUNCT_W-1:0] dec_alu;
  logic               dec_mem, dec_store, dec_halt, dec_illegal;

  ctrl_t              ctrl_o;
  logic [FUNCT_W-1:0] alu_o;
  logic               mem_req_o, mem_write_o, ir_write_o, pc_write_o;

  control_decode #(
    .INST_W    (INST_W),
    .FUNCT_W   (FUNCT_W),
    .NUM_FUNCT (NUM_FUNCT)
  ) u_decode (
    .ir         (ir_q),
    .ctrl       (dec_ctrl),
    .alu_op     (dec_alu),
    .is_mem     (dec_mem),
    .is_store   (dec_store),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.mem_ack) begin
          ir_d    = bus.inst;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_halt)         state_d = ST_HALT;
        else if (dec_illegal) state_d = ST_TRAP;
        else if (dec_mem)     state_d = ST_MEM;
        else                  state_d = ST_EXEC;
      end
      ST_EXEC: begin
        retired_d = retired_q + 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          retired_d = retired_q + 1'b1;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    ctrl_o      = '0;
    alu_o       = '0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_o  = 1'b1;
        ir_write_o = bus.mem_ack;
      end
      ST_EXEC: begin
        ctrl_o     = dec_ctrl;
        alu_o      = dec_alu;
        pc_write_o = 1'b1;
      end
      ST_MEM: begin
        mem_req_o   = 1'b1;
        mem_write_o = dec_store;
        if (bus.mem_ack) begin
          ctrl_o     = dec_ctrl;
          pc_write_o = 1'b1;
        end
      end
      default: ;
    endcase
    // FETCH would otherwise request memory while reset is held.
    if (!reset) begin
      mem_req_o  = 1'b0;
      ir_write_o = 1'b0;
    end
  end

  assign bus.mem_req   = mem_req_o;
  assign bus.MemWrite  = mem_write_o;
  assign IRWrite       = ir_write_o;
  assign stackOP       = ctrl_o.stack_op;
  assign rStackOP      = ctrl_o.rstack_op;
  assign stackControl  = ctrl_o.stack_ctrl;
  assign PCControl     = ctrl_o.pc_ctrl;
  assign ALUOP         = alu_o;
  assign PCWrite       = pc_write_o;
  assign halted        = (state_q == ST_HALT);
  assign trap          = (state_q == ST_TRAP);
  assign retired       = retired_q;

endmodule

// File: tb/tb_control_mc.sv
// Directed testbench for control_mc: inputs change on the falling edge and
// outputs are sampled 1 time unit later.
module tb_control_mc;

  logic        CLK = 1'b0;
  logic        reset;
  logic        IRWrite, PCWrite, halted, trap;
  logic [2:0]  stackOP, stackControl, PCControl;
  logic [1:0]  rStackOP;
  logic [3:0]  ALUOP;
  logic [15:0] retired;

  int checks   = 0;
  int failures = 0;

  control_mc_if #(.INST_W(16)) bus ();

  control_mc dut (
    .CLK          (CLK),
    .reset        (reset),
    .bus          (bus.master),
    .IRWrite      (IRWrite),
    .stackOP      (stackOP),
    .rStackOP     (rStackOP),
    .stackControl (stackControl),
    .PCControl    (PCControl),
    .ALUOP        (ALUOP),
    .PCWrite      (PCWrite),
    .halted       (halted),
    .trap         (trap),
    .retired      (retired)
  );

  always #5 CLK = ~CLK;

  // {mem_req, MemWrite, IRWrite, PCWrite, stackOP, rStackOP, stackControl, PCControl, ALUOP}
  function automatic logic [18:0] obs();
    return {bus.mem_req, bus.MemWrite, IRWrite, PCWrite, stackOP, rStackOP,
            stackControl, PCControl, ALUOP};
  endfunction

  function automatic logic [18:0] w(input logic mr, input logic mw, input logic irw,
                                    input logic pcw, input logic [2:0] so,
                                    input logic [1:0] rs, input logic [2:0] sc,
                                    input logic [2:0] pc, input logic [3:0] alu);
    return {mr, mw, irw, pcw, so, rs, sc, pc, alu};
  endfunction

  task automatic tick(input logic [15:0] i, input logic ack);
    @(negedge CLK);
    bus.inst    = i;
    bus.mem_ack = ack;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset       = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    @(negedge CLK);
    reset = 1'b1;
  endtask

  // Fetch with immediate ack, then the DECODE cycle; returns before the following cycle.
  task automatic run_fetch(input logic [15:0] i);
    tick(i, 1'b1);
    checks++;
    if (obs() !== w(1,0,1,0,0,0,0,0,0)) begin
      failures++;
      $display("FAIL fetch_%h: got %h want %h", i, obs(), w(1,0,1,0,0,0,0,0,0));
    end
    tick(16'hFFFF, 1'b0);
    checks++;
    if (obs() !== 19'd0) begin
      failures++;
      $display("FAIL decode_%h: got %h want 0", i, obs());
    end
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    bus.inst    = 16'h1234;
    bus.mem_ack = 1'b1;
    #1;
    @(negedge CLK);
    checks++;
    if (obs() !== 19'd0 || halted !== 1'b0 || trap !== 1'b0 || retired !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h h%b t%b r%0d want all 0", obs(), halted, trap, retired);
    end
    bus.mem_ack = 1'b0;
    reset       = 1'b1;
    #1;
    checks++;
    if (obs() !== w(1,0,0,0,0,0,0,0,0)) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", obs(), w(1,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_alu_basic();
    run_fetch(16'h0000);
    tick(16'h0000, 1'b0);
    checks++;
    if (obs() !== w(0,0,0,1,2,0,3,4,0)) begin
      failures++;
      $display("FAIL alu_exec: got %h want %h", obs(), w(0,0,0,1,2,0,3,4,0));
    end
    tick(16'h0000, 1'b0);
    checks++;
    if (retired !== 16'd1 || obs() !== w(1,0,0,0,0,0,0,0,0)) begin
      failures++;
      $display("FAIL alu_retire: got r=%0d %h want r=1 %h", retired, obs(), w(1,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_alu_sweep();
    do_reset();
    for (int f = 0; f < 12; f++) begin
      run_fetch(16'(f));
      tick(16'h0000, 1'b0);
      checks++;
      if (obs() !== w(0,0,0,1,2,0,3,4,4'(f))) begin
        failures++;
        $display("FAIL sweep_f%0d: got %h want %h", f, obs(), w(0,0,0,1,2,0,3,4,4'(f)));
      end
    end
    run_fetch(16'h000C);
    tick(16'h0000, 1'b1);
    checks++;
    if (trap !== 1'b1 || halted !== 1'b0 || obs() !== 19'd0 || retired !== 16'd12) begin
      failures++;
      $display("FAIL trap_entry: got t%b h%b %h r=%0d want t1 h0 0 r=12", trap, halted, obs(), retired);
    end
    tick(16'h0000, 1'b1);
    checks++;
    if (trap !== 1'b1 || obs() !== 19'd0 || retired !== 16'd12) begin
      failures++;
      $display("FAIL trap_hold: got t%b %h r=%0d want t1 0 r=12", trap, obs(), retired);
    end
  endtask

  task automatic test_store_wait();
    int req_cycles;
    do_reset();
    run_fetch(16'h3000);
    req_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      tick(16'h0000, 1'b0);
      if (bus.mem_req === 1'b1 && bus.MemWrite === 1'b1) req_cycles++;
      checks++;
      if (obs() !== w(1,1,0,0,0,0,0,0,0)) begin
        failures++;
        $display("FAIL store_wait_c%0d: got %h want %h", c, obs(), w(1,1,0,0,0,0,0,0,0));
      end
    end
    tick(16'h0000, 1'b1);
    if (bus.mem_req === 1'b1 && bus.MemWrite === 1'b1) req_cycles++;
    checks++;
    if (obs() !== w(1,1,0,1,3,0,0,4,0)) begin
      failures++;
      $display("FAIL store_ack: got %h want %h", obs(), w(1,1,0,1,3,0,0,4,0));
    end
    checks++;
    if (req_cycles !== 4) begin
      failures++;
      $display("FAIL store_req_cycles: got %0d want 4", req_cycles);
    end
    tick(16'h0000, 1'b0);
    checks++;
    if (retired !== 16'd1 || obs() !== w(1,0,0,0,0,0,0,0,0)) begin
      failures++;
      $display("FAIL store_retire: got r=%0d %h want r=1 %h", retired, obs(), w(1,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_load();
    run_fetch(16'h2000);
    tick(16'h0000, 1'b1);
    checks++;
    if (obs() !== w(1,0,0,1,4,0,2,4,0)) begin
      failures++;
      $display("FAIL load_ack: got %h want %h", obs(), w(1,0,0,1,4,0,2,4,0));
    end
  endtask

  task automatic test_flow_ops();
    logic [15:0] ops  [5] = '{16'h6000, 16'h7000, 16'h4000, 16'h5000, 16'h1ABC};
    logic [18:0] want [5];
    want[0] = w(0,0,0,1,0,1,0,1,0);
    want[1] = w(0,0,0,1,0,2,0,3,0);
    want[2] = w(0,0,0,1,0,0,0,1,0);
    want[3] = w(0,0,0,1,3,0,0,2,0);
    want[4] = w(0,0,0,1,1,0,1,4,0);
    for (int k = 0; k < 5; k++) begin
      run_fetch(ops[k]);
      tick(16'h0000, 1'b0);
      checks++;
      if (obs() !== want[k]) begin
        failures++;
        $display("FAIL exec_%h: got %h want %h", ops[k], obs(), want[k]);
      end
    end
    tick(16'h0000, 1'b0);
    checks++;
    if (retired !== 16'd7) begin
      failures++;
      $display("FAIL flow_retired: got %0d want 7", retired);
    end
  endtask

  task automatic test_reset_mid_mem();
    run_fetch(16'h2000);
    tick(16'h0000, 1'b0);
    checks++;
    if (obs() !== w(1,0,0,0,0,0,0,0,0)) begin
      failures++;
      $display("FAIL midmem_pre: got %h want %h", obs(), w(1,0,0,0,0,0,0,0,0));
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== 19'd0 || retired !== 16'd0) begin
      failures++;
      $display("FAIL midmem_reset: got %h r=%0d want 0 r=0", obs(), retired);
    end
    @(negedge CLK);
    reset = 1'b1;
    #1;
    checks++;
    if (obs() !== w(1,0,0,0,0,0,0,0,0) || retired !== 16'd0) begin
      failures++;
      $display("FAIL midmem_release: got %h r=%0d want %h r=0", obs(), retired, w(1,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_halt();
    run_fetch(16'h1005);
    tick(16'h0000, 1'b0);
    run_fetch(16'h8000);
    for (int c = 0; c < 10; c++) begin
      tick(16'h0123, c[0]);
      checks++;
      if (halted !== 1'b1 || bus.mem_req !== 1'b0 || obs() !== 19'd0 || retired !== 16'd1) begin
        failures++;
        $display("FAIL halt_c%0d: got h%b req%b %h r=%0d want h1 req0 0 r=1", c, halted, bus.mem_req, obs(), retired);
      end
    end
    @(negedge CLK);
    reset       = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || obs() !== 19'd0) begin
      failures++;
      $display("FAIL halt_reset: got h%b %h want h0 0", halted, obs());
    end
    @(negedge CLK);
    reset = 1'b1;
    #1;
    checks++;
    if (obs() !== w(1,0,0,0,0,0,0,0,0) || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_refetch: got %h h%b want %h h0", obs(), halted, w(1,0,0,0,0,0,0,0,0));
    end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_alu_sweep();
    test_store_wait();
    test_load();
    test_flow_ops();
    test_reset_mid_mem();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_mc.md
CONTROL_MC -- requirements
Module: control_mc

Interface
REQ-001 Parameter INST_W, default 16, instruction word width; opcode is always inst[INST_W-1:INST_W-4].
REQ-002 Parameter FUNCT_W, default 4, ALU function field width; field is inst[FUNCT_W-1:0].
REQ-003 Parameter NUM_FUNCT, default 12, count of legal ALU functions (0..NUM_FUNCT-1).
REQ-004 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-005 CLK  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 inst  input  INST_W  instruction word from memory, valid when mem_ack=1 in FETCH.
REQ-008 mem_ack  input  1  memory completes the current request this cycle.
REQ-009 mem_req  output  1  memory request, held until mem_ack.
REQ-010 MemWrite  output  1  current request is a write.
REQ-011 IRWrite  output  1  instruction register loads inst this cycle.
REQ-012 stackOP  output  3  0 NOP, 1 PUSH, 2 POP2PUSH1, 3 POP, 4 POP1PUSH1.
REQ-013 rStackOP  output  2  0 NOP, 1 PUSH, 2 POP.
REQ-014 stackControl  output  3  TOS source: 0 none, 1 immediate, 2 memory, 3 ALU, 4 rstack top.
REQ-015 PCControl  output  3  0 hold, 1 jump imm, 2 branch-if-zero imm, 3 rstack top, 4 PC+1.
REQ-016 ALUOP  output  FUNCT_W  ALU function.
REQ-017 PCWrite  output  1  PC updates this cycle.
REQ-018 halted, trap  output  1 each  status flags.
REQ-019 retired  output  CNT_W  count of completed instructions.

Function
REQ-020 States: FETCH, DECODE, EXEC, MEM, HALT, TRAP; reset state FETCH.
REQ-021 FETCH: mem_req=1, MemWrite=0; on mem_ack: IRWrite=1, IR<=inst, next DECODE; else remain.
REQ-022 DECODE: one cycle, all control outputs 0; opcode 8 -> HALT; opcode 9..15, or opcode 0 with funct>=NUM_FUNCT -> TRAP; LOAD/STORE -> MEM; otherwise -> EXEC.
REQ-023 EXEC: one cycle, decoded controls asserted, PCWrite=1, retired+1, next FETCH.
REQ-024 Opcode 0 ALU: stackOP=2, rStackOP=0, stackControl=3, PCControl=4, ALUOP=funct.
REQ-025 Opcode 1 PUSHI: stackOP=1, stackControl=1, PCControl=4.
REQ-026 Opcode 2 LOAD (MEM): mem_req=1, MemWrite=0; on ack cycle stackOP=4, stackControl=2, PCControl=4, PCWrite=1.
REQ-027 Opcode 3 STORE (MEM): mem_req=1, MemWrite=1; on ack cycle stackOP=3, PCControl=4, PCWrite=1.
REQ-028 MEM without mem_ack: controls other than mem_req/MemWrite are 0, PCWrite=0; on ack retired+1, next FETCH.
REQ-029 Opcode 4 JUMP: PCControl=1; opcode 5 BZ: stackOP=3, PCControl=2; opcode 6 CALL: rStackOP=1, PCControl=1; opcode 7 RET: rStackOP=2, PCControl=3.
REQ-030 Unused outputs in any state are 0; ALUOP=0 except opcode 0 in EXEC.
REQ-031 HALT: halted=1, all controls 0, held until reset; retired unchanged.
REQ-032 TRAP: trap=1, all controls 0, held until reset; trapping instruction not counted.
REQ-033 retired wraps modulo 2^CNT_W without saturation.
REQ-034 Control outputs are combinational from state, IR, mem_ack; no glitch requirement beyond synchronous use.

Reset
REQ-035 reset=0 forces, asynchronously, state=FETCH, IR=0, retired=0, halted=0, trap=0.
REQ-036 During reset, every output is 0 except mem_req, which is also 0 while reset=0.
REQ-037 Reset mid-MEM or mid-FETCH abandons the request; first cycle after release issues a new fetch.

Structure
REQ-038 Package control_pkg holds state enum, opcode constants, stackOP/rStackOP/stackControl/PCControl encodings.
REQ-039 One sub-module control_decode: combinational IR -> control word and illegal/halt/mem flags; FSM and counter in control_mc.

Verification
REQ-040 Fetch 0x0000 with immediate ack -> DECODE then EXEC: stackOP=2, rStackOP=0, ALUOP=0, stackControl=3, PCControl=4, MemWrite=0, PCWrite=1; retired=1.
REQ-041 Sweep 0x0000..0x000B -> ALUOP equals funct each EXEC; 0x000C -> trap=1 on cycle after DECODE, retired=12.
REQ-042 Fetch 0x3000, mem_ack delayed 3 cycles in MEM -> mem_req=1, MemWrite=1 for 4 cycles, PCWrite=1 only on ack cycle.
REQ-043 Fetch 0x6000 then 0x7000 -> rStackOP=1/PCControl=1 then rStackOP=2/PCControl=3.
REQ-044 Fetch 0x8000 -> halted=1, mem_req stays 0 for 10 cycles; reset low -> halted=0, FETCH.
REQ-045 Reset asserted mid-MEM of 0x2000 -> outputs 0 immediately, after release mem_req=1, MemWrite=0, retired=0.
